// File: rtl/ultrasonic_pkg.sv
// Shared types and default timing for the ultrasonic ranging engine and the motor controller.
// Default constants assume a 125 MHz core clock.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_e;

  localparam int DEF_NUM_CH         = 2;
  localparam int DEF_CNT_W          = 24;
  localparam int DEF_TRIG_CYCLES    = 3000;
  localparam int DEF_PERIOD_CYCLES  = 8500000;
  localparam int DEF_TIMEOUT_CYCLES = 7500000;
  localparam int DEF_NEAR_THRESH    = 304500;
  localparam int DEF_NEAR_HYST      = 20000;

  function automatic int ch_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/echo_sync.sv
// Parametrised-width 2-flop synchroniser for asynchronous sensor pins; output lags by two clk edges.
module echo_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/ultrasonic_scanner.sv
// Round-robin multi-channel ultrasonic ranging: one trigger/measure slot per sensor, results valid 3 cycles after echo falls.
// NEAR_HYST_EN: when defined, the near flag uses a set/release hysteresis band of NEAR_HYST cycles.
module ultrasonic_scanner
  import ultrasonic_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int NEAR_THRESH    = DEF_NEAR_THRESH,
  parameter int NEAR_HYST      = DEF_NEAR_HYST
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       echo,
  output logic [NUM_CH-1:0]       trig,
  output logic [NUM_CH*CNT_W-1:0] width,
  output logic [NUM_CH-1:0]       valid,
  output logic [NUM_CH-1:0]       timeout,
  output logic [NUM_CH-1:0]       near,
  output logic                    busy
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_AT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] NEAR_LVL    = CNT_W'(NEAR_THRESH);
  localparam logic [CH_W-1:0]  CH_LAST     = CH_W'(NUM_CH - 1);
`ifdef NEAR_HYST_EN
  localparam logic [CNT_W-1:0] FAR_LVL     = CNT_W'(NEAR_THRESH + NEAR_HYST);
`endif

  if ((NUM_CH < 1) || (NUM_CH > 8) ||
      (TRIG_CYCLES < 1) || (TRIG_CYCLES >= TIMEOUT_CYCLES) ||
      (TIMEOUT_CYCLES >= PERIOD_CYCLES) ||
      ((64'd1 << CNT_W) <= 64'(PERIOD_CYCLES)) ||
      (NEAR_HYST < 0) ||
      ((64'd1 << CNT_W) <= 64'(NEAR_THRESH + NEAR_HYST))) begin : g_bad_cfg
    $error("ultrasonic_scanner: inconsistent timing parameters");
  end

  logic [NUM_CH-1:0] echo_s;

  echo_sync #(.W(NUM_CH)) u_echo_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (echo),
    .sync_o  (echo_s)
  );

  state_e                        state_q, state_d;
  logic [CH_W-1:0]               ch_q, ch_d;
  logic [CNT_W-1:0]              slot_q, slot_d;
  logic [CNT_W-1:0]              echo_cnt_q, echo_cnt_d;
  logic                          echo_prev_q, echo_prev_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  width_q, width_d;
  logic [NUM_CH-1:0]             valid_q, valid_d;
  logic [NUM_CH-1:0]             timeout_q, timeout_d;
  logic [NUM_CH-1:0]             near_q, near_d;

  logic              echo_cur;
  logic              done;
  logic              done_to;
  logic [NUM_CH-1:0] ch_oh;

  assign echo_cur = echo_s[ch_q];
  assign ch_oh    = NUM_CH'(1) << ch_q;

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    slot_d      = slot_q + 1'b1;
    echo_cnt_d  = echo_cnt_q;
    echo_prev_d = echo_cur;
    done        = 1'b0;
    done_to     = 1'b0;

    case (state_q)
      IDLE: begin
        slot_d = '0;
        if (enable) state_d = TRIG;
      end
      TRIG: begin
        if (slot_q == TRIG_LAST) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (slot_q == TIMEOUT_AT) begin
          done    = 1'b1;
          done_to = 1'b1;
        end else if (echo_cur && !echo_prev_q) begin
          // The rising cycle is itself one high cycle of the pulse.
          echo_cnt_d = CNT_W'(1);
          state_d    = MEASURE;
        end
      end
      MEASURE: begin
        if (slot_q == TIMEOUT_AT) begin
          done    = 1'b1;
          done_to = 1'b1;
        end else if (echo_cur) begin
          echo_cnt_d = (&echo_cnt_q) ? echo_cnt_q : echo_cnt_q + 1'b1;
        end else begin
          done = 1'b1;
        end
      end
      HOLDOFF: begin
        if (slot_q == PERIOD_LAST) begin
          slot_d  = '0;
          ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
          state_d = enable ? TRIG : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        slot_d  = '0;
      end
    endcase

    if (done) state_d = HOLDOFF;
  end

  always_comb begin
    width_d   = width_q;
    timeout_d = timeout_q;
    near_d    = near_q;
    valid_d   = '0;
    if (done) begin
      valid_d[ch_q]   = 1'b1;
      timeout_d[ch_q] = done_to;
      if (done_to) begin
        width_d[ch_q] = '1;
        near_d[ch_q]  = 1'b0;
      end else begin
        width_d[ch_q] = echo_cnt_q;
`ifdef NEAR_HYST_EN
        if (echo_cnt_q < NEAR_LVL)      near_d[ch_q] = 1'b1;
        else if (echo_cnt_q >= FAR_LVL) near_d[ch_q] = 1'b0;
`else
        near_d[ch_q] = (echo_cnt_q < NEAR_LVL);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      slot_q      <= '0;
      echo_cnt_q  <= '0;
      echo_prev_q <= 1'b0;
      width_q     <= '0;
      valid_q     <= '0;
      timeout_q   <= '0;
      near_q      <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      slot_q      <= slot_d;
      echo_cnt_q  <= echo_cnt_d;
      echo_prev_q <= echo_prev_d;
      width_q     <= width_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      near_q      <= near_d;
    end
  end

  assign trig    = (state_q == TRIG) ? ch_oh : '0;
  assign width   = width_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign near    = near_q;
  assign busy    = (state_q != IDLE);

endmodule
